// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//
// Burst-aware round-robin arbiter for the shared AHB system bus. Requests
// from up to NUM_MASTERS masters are granted one at a time (one-hot HGRANT).
// A fixed-length burst is never split: the grant moves on only when the
// beat being accepted is the second-to-last address phase or later, so the
// new owner's first address phase directly follows the old owner's last one.
// Locked sequences keep the grant until the owner drops HLOCK or HBUSREQ.
// With no requester the bus parks on DEFAULT_MASTER.
//
// Ports:
//   HCLK       in   bus clock, all state on rising edge
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQ    in   [NUM_MASTERS] bus request per master
//   HLOCK      in   [NUM_MASTERS] locked-transfer request per master
//   HTRANS     in   [2] muxed bus transfer type
//   HBURST     in   [3] muxed bus burst type
//   HREADY     in   bus ready from the interconnect
//   HRESP      in   [2] bus response
//   HGRANT     out  [NUM_MASTERS] one-hot grant, registered
//   HMASTER    out  [MIDX_W] address-phase owner, registered
//   HMASTER_D  out  [MIDX_W] data-phase owner (HWDATA select), registered
//   HMASTLOCK  out  address phase in flight is locked, registered
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MIDX_W         = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MIDX_W-1:0]      HMASTER,
    output logic [MIDX_W-1:0]      HMASTER_D,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam int CNT_W = 4;

    localparam logic [MIDX_W-1:0]      DEFAULT_IDX   = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] ONE_VEC       = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = ONE_VEC << DEFAULT_MASTER;

    // True for the fixed-length burst types (WRAP4/INCR4 .. WRAP16/INCR16).
    function automatic logic burst_fixed(input logic [2:0] hburst);
        logic fixed_v;
        case (hburst)
            3'b000, 3'b001: fixed_v = 1'b0;
            default:        fixed_v = 1'b1;
        endcase
        return fixed_v;
    endfunction

    // Beats remaining after the first beat of a fixed burst (length - 1).
    function automatic logic [CNT_W-1:0] burst_rest(input logic [2:0] hburst);
        logic [CNT_W-1:0] rest_v;
        case (hburst)
            3'b010, 3'b011: rest_v = 4'd3;
            3'b100, 3'b101: rest_v = 4'd7;
            3'b110, 3'b111: rest_v = 4'd15;
            default:        rest_v = 4'd0;
        endcase
        return rest_v;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [MIDX_W-1:0] idx);
        return ONE_VEC << idx;
    endfunction

    logic [NUM_MASTERS-1:0] hgrant_r;
    logic [MIDX_W-1:0]      grant_idx_r;
    logic [MIDX_W-1:0]      rr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [MIDX_W-1:0]      hmaster_r;
    logic [MIDX_W-1:0]      hmaster_d_r;
    logic                   hmastlock_r;

    logic [CNT_W-1:0]       cnt_next_s;
    logic                   locked_s;
    logic                   rearb_ok_s;
    logic                   found_s;
    logic [MIDX_W-1:0]      winner_s;
    logic [MIDX_W-1:0]      cand_s;
    logic                   hit_s;

    // Beat counter next state: tracks address phases left in a fixed burst.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!HREADY) begin
            // An error/retry/split first cycle aborts the burst immediately.
            if (HRESP != RESP_OKAY) begin
                cnt_next_s = 4'd0;
            end else begin
                cnt_next_s = cnt_r;
            end
        end else if ((HTRANS == TRANS_NONSEQ) && burst_fixed(HBURST)) begin
            cnt_next_s = burst_rest(HBURST);
        end else if ((HTRANS == TRANS_SEQ) && (cnt_r != 4'd0)) begin
            cnt_next_s = cnt_r - 4'd1;
        end else if (HTRANS == TRANS_IDLE) begin
            cnt_next_s = 4'd0;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Re-arbitration window: no lock held, not mid-BUSY, and at most the
    // final beat of the burst still to come.
    always_comb begin
        locked_s   = HLOCK[grant_idx_r] & HBUSREQ[grant_idx_r];
        rearb_ok_s = HREADY & ~locked_s & (HTRANS != TRANS_BUSY) & (cnt_next_s <= 4'd1);
    end

    // Round-robin search starting just after the last winner; the last
    // winner itself is tried last, so a sole requester keeps the bus.
    always_comb begin
        found_s  = 1'b0;
        winner_s = rr_r;
        cand_s   = rr_r;
        hit_s    = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_s   = MIDX_W'((int'(rr_r) + i) % NUM_MASTERS);
            hit_s    = ~found_s & HBUSREQ[cand_s];
            winner_s = hit_s ? cand_s : winner_s;
            found_s  = found_s | hit_s;
        end
    end

    // Beat counter register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // Grant register and round-robin pointer; parking leaves the pointer alone.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_r    <= DEFAULT_GRANT;
            grant_idx_r <= DEFAULT_IDX;
            rr_r        <= DEFAULT_IDX;
        end else if (rearb_ok_s) begin
            if (found_s) begin
                hgrant_r    <= idx_to_onehot(winner_s);
                grant_idx_r <= winner_s;
                rr_r        <= winner_s;
            end else begin
                hgrant_r    <= DEFAULT_GRANT;
                grant_idx_r <= DEFAULT_IDX;
            end
        end
    end

    // Ownership pipeline: address phase follows the grant, data phase follows
    // the address phase; wait states stretch both.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmaster_r   <= DEFAULT_IDX;
            hmaster_d_r <= DEFAULT_IDX;
            hmastlock_r <= 1'b0;
        end else if (HREADY) begin
            hmaster_r   <= grant_idx_r;
            hmaster_d_r <= hmaster_r;
            hmastlock_r <= HLOCK[grant_idx_r];
        end
    end

    assign HGRANT    = hgrant_r;
    assign HMASTER   = hmaster_r;
    assign HMASTER_D = hmaster_d_r;
    assign HMASTLOCK = hmastlock_r;

    ahb_bus_arbiter_chk #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_chk (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D)
    );

endmodule

// ---------------------------------------------------------------------------
// ahb_bus_arbiter_chk
//
// Structural invariants of the arbiter outputs: the grant is one-hot and
// both owner indices name an existing master.
//
// Ports:
//   HCLK, HRESETn  in  clock and reset of the observed arbiter
//   HGRANT         in  [NUM_MASTERS] grant vector
//   HMASTER        in  [MIDX_W] address-phase owner
//   HMASTER_D      in  [MIDX_W] data-phase owner
// ---------------------------------------------------------------------------
module ahb_bus_arbiter_chk #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2
) (
    input logic                   HCLK,
    input logic                   HRESETn,
    input logic [NUM_MASTERS-1:0] HGRANT,
    input logic [MIDX_W-1:0]      HMASTER,
    input logic [MIDX_W-1:0]      HMASTER_D
);

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot(HGRANT));

    a_master_range: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (int'(HMASTER) < NUM_MASTERS) && (int'(HMASTER_D) < NUM_MASTERS));

endmodule
